// File: rtl/types_pkg.sv
// Shared types for the core/data-memory path.
package types_pkg;

  localparam int MEM_SIZE = 1024;

  typedef logic [31:0] word_t;
  typedef logic [$clog2(MEM_SIZE)-1:0] address_t;

  // Encoding 2'b11 is deliberately left out: it is an illegal request size.
  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } access_size_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Lane steering for the load/store unit (little-endian).
// Extracts and extends a load lane, and merges new store data into a word.
module lsu_lane_align
  import types_pkg::*;
(
  input  word_t       word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  word_t       new_data,
  output word_t       load_val,
  output word_t       merged
);

  word_t shifted;

  // Shift the addressed lane down to bit 0, then extend or merge by size.
  always_comb begin
    shifted  = word >> {off, 3'b000};
    load_val = word;
    merged   = new_data;
    case (size)
      SIZE_B: begin
        load_val = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
        merged   = word;
        merged[{off, 3'b000} +: 8] = new_data[7:0];
      end
      SIZE_H: begin
        load_val = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
        merged   = word;
        merged[{off[1], 4'b0000} +: 16] = new_data[15:0];
      end
      default: begin
        load_val = word;
        merged   = new_data;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Core-side initiator for the word-wide single-port data memory.
// Sub-word stores are done as read-modify-write since the memory has no byte strobes.
module load_store_unit
  import types_pkg::*;
#(
  parameter  int MEM_WORDS = MEM_SIZE,
  localparam int ADDR_W    = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, LD_REQ, LD_CAP, ST_WR, RMW_RD, RMW_WR, RESP
  } lsu_state_t;

  lsu_state_t        state;
  logic [ADDR_W+1:0] addr_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  word_t             wdata_q;

  logic              req_err;
  word_t             load_val;
  word_t             merged;

  // Misaligned, illegal-size or out-of-range requests never touch memory.
  always_comb begin
    req_err = (req_size == 2'b11)
           || (req_size == SIZE_H && req_addr[0])
           || (req_size == SIZE_W && req_addr[1:0] != 2'b00)
           || ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
  end

  lsu_lane_align u_align (
    .word        (mem_rdata),
    .off         (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .new_data    (wdata_q),
    .load_val    (load_val),
    .merged      (merged)
  );

  // Request sequencing: capture at accept, walk the access, pulse RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q     <= req_addr[ADDR_W+1:0];
          size_q     <= req_size;
          unsigned_q <= req_unsigned;
          wdata_q    <= req_wdata;
          resp_rdata <= '0;
          resp_err   <= req_err;
          if (req_err)              state <= RESP;
          else if (!req_write)      state <= LD_REQ;
          else if (req_size == SIZE_W) state <= ST_WR;
          else                      state <= RMW_RD;
        end
        LD_REQ: state <= LD_CAP;
        LD_CAP: begin
          resp_rdata <= load_val;
          state      <= RESP;
        end
        ST_WR:  state <= RESP;
        RMW_RD: state <= RMW_WR;
        RMW_WR: state <= RESP;
        RESP:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write enable and data follow the state, so reset kills a write at once.
  always_comb begin
    mem_we    = (state == ST_WR) || (state == RMW_WR);
    mem_wdata = '0;
    if (state == ST_WR)  mem_wdata = wdata_q;
    if (state == RMW_WR) mem_wdata = merged;
  end

  assign mem_addr   = addr_q[ADDR_W+1:2];
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, reset-during-RMW sequence, random vs byte-array model.
module tb_load_store_unit;

  localparam int MW = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem [MW];
  logic [7:0]  refmem [MW*4];

  int checks = 0;
  int errors = 0;

  load_store_unit #(.MEM_WORDS(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory with registered read.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed memory, little-endian, plain arithmetic.
  function automatic void model(input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] rd, output logic er,
                                output int lat, output int wes);
    int nb;
    longint val;
    nb = 1 << sz;
    er = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
      || (a / 4 >= MW);
    rd = '0; wes = 0;
    if (er) begin
      lat = 1;
    end else if (w) begin
      for (int i = 0; i < nb; i++) refmem[a + i] = d[8*i +: 8];
      lat = (nb == 4) ? 2 : 3;
      wes = 1;
    end else begin
      val = 0;
      for (int i = 0; i < nb; i++) val = val + (longint'(refmem[a + i]) << (8 * i));
      if (!u && val[8*nb-1]) val = val - (64'sd1 << (8 * nb));
      rd = val[31:0];
      lat = 3;
    end
  endfunction

  // One request; returns response, latency from accept and mem_we cycle count.
  task automatic txn(input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er,
                     output int lat, output int wes);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; wes = 0; rd = 'x; er = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_we) wes++;
      if (resp_valid) begin
        lat = c; rd = resp_rdata; er = resp_err;
        break;
      end
    end
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  vec_t tbl[17];

  initial begin
    logic [31:0] rd, mrd;
    logic er, mer;
    int lat, wes, mlat, mwes;

    for (int i = 0; i < MW; i++) mem[i] = '0;
    for (int i = 0; i < MW*4; i++) refmem[i] = '0;

    //        w     sz     u     addr        wdata          rdata          err
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h12,  32'h0000005A, 32'h00000000, 1'b0};
    tbl[3]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDE5ABEEF, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        32'h000000DE, 1'b0};
    tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h12,  32'h0,        32'hFFFFDE5A, 1'b0};
    tbl[7]  = '{1'b1, 2'd1, 1'b0, 32'h11,  32'h0000FFFF, 32'h00000000, 1'b1};
    tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h12,  32'h0,        32'h00000000, 1'b1};
    tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDE5ABEEF, 1'b0};
    tbl[10] = '{1'b0, 2'd2, 1'b0, MW*4,    32'h0,        32'h00000000, 1'b1};
    tbl[11] = '{1'b0, 2'd3, 1'b0, 32'h10,  32'h0,        32'h00000000, 1'b1};
    tbl[12] = '{1'b1, 2'd1, 1'b0, 32'h16,  32'hABCD1234, 32'h00000000, 1'b0};
    tbl[13] = '{1'b0, 2'd2, 1'b0, 32'h14,  32'h0,        32'h12340000, 1'b0};
    tbl[14] = '{1'b0, 2'd1, 1'b1, 32'h16,  32'h0,        32'h00001234, 1'b0};
    tbl[15] = '{1'b0, 2'd0, 1'b0, 32'h10,  32'h0,        32'hFFFFFFEF, 1'b0};
    tbl[16] = '{1'b0, 2'd2, 1'b0, MW*4-4,  32'h0,        32'h00000000, 1'b0};

    // Reset values while held in reset and just after release.
    #2;
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_mem_addr", {26'b0, mem_addr}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'h0);

    // Directed table.
    for (int i = 0; i < 17; i++) begin
      txn(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].d, rd, er, lat, wes);
      model(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].d, mrd, mer, mlat, mwes);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d_err", i), {31'b0, er}, {31'b0, tbl[i].er});
      chk($sformatf("tbl%0d_lat", i), lat, mlat);
      chk($sformatf("tbl%0d_we", i), wes, mwes);
    end
    chk("mem_word4_unchanged", mem[4], 32'hDE5ABEEF);

    // Reset during RMW_WR: write must not commit, no response afterwards.
    txn(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, rd, er, lat, wes);
    model(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, mrd, mer, mlat, mwes);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h21; req_wdata = 32'hFF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 chk("rmw_we_before_rst", {31'b0, mem_we}, 32'h1);
    rst_n = 1'b0;
    #1 chk("rmw_we_async_drop", {31'b0, mem_we}, 32'h0);
    @(posedge clk);
    #1 chk("rmw_word_unchanged", mem[8], 32'h11223344);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_ready", {31'b0, req_ready}, 32'h1);
      chk("post_rst_no_resp", {31'b0, resp_valid}, 32'h0);
    end

    // Random traffic against the byte-array model.
    for (int n = 0; n < 300; n++) begin
      logic w, u;
      logic [1:0] sz;
      logic [31:0] a, d;
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(MW, MW + 8)) * 4
                                        : 32'($urandom_range(0, MW - 1)) * 4;
      a  = a + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      d  = $urandom;
      txn(w, sz, u, a, d, rd, er, lat, wes);
      model(w, sz, u, a, d, mrd, mer, mlat, mwes);
      chk($sformatf("rnd%0d_rdata a=%h", n, a), rd, mrd);
      chk($sformatf("rnd%0d_err", n), {31'b0, er}, {31'b0, mer});
      chk($sformatf("rnd%0d_lat", n), lat, mlat);
      chk($sformatf("rnd%0d_we", n), wes, mwes);
    end

    // Final memory image must match the model.
    for (int i = 0; i < MW; i++)
      chk($sformatf("final_mem%0d", i), mem[i],
          {refmem[4*i+3], refmem[4*i+2], refmem[4*i+1], refmem[4*i]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the word-wide, single-port data memory: accepts byte/halfword/word load and store requests from the datapath, drives the memory's word address, write-enable and write-data, and returns aligned, extended load data. Sub-word stores use an internal read-modify-write sequence because the memory has one write enable and no byte strobes. It sits between the execute stage and the data memory and stalls the core through a ready/valid handshake.

## Interface
- `MEM_WORDS`, default `MEM_SIZE`: number of 32-bit memory words; word index width is `$clog2(MEM_WORDS)`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  access size, `access_size_t`: B=00, H=01, W=10; 11 is illegal.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned, out-of-range, or illegal size; qualified by `resp_valid`.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  `address_t`  memory word index.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data; registered, valid the cycle after the address is presented.

## Operation
- Accept on `req_valid && req_ready`; capture addr, size, write, unsigned, wdata into registers.
- Error check at accept: H with `addr[0]`=1, W with `addr[1:0]`≠0, size 11, or `addr[31:2]` ≥ `MEM_WORDS` → go to RESP with `resp_err`=1; no memory write ever occurs.
- FSM `lsu_state_t`: IDLE, LD_REQ, LD_CAP, ST_WR, RMW_RD, RMW_WR, RESP.
  - Load: IDLE→LD_REQ→LD_CAP→RESP.
  - Word store: IDLE→ST_WR→RESP.
  - B/H store: IDLE→RMW_RD→RMW_WR→RESP.
  - RESP→IDLE unconditionally.
- `mem_addr` = registered `addr[ADDR_W+1:2]` in all states.
- `mem_we` is combinational from state: 1 only in ST_WR and RMW_WR.
- `mem_wdata`:
  - ST_WR: the registered wdata.
  - RMW_WR: `mem_rdata` with the target lane replaced. Byte lane = `addr[1:0]`; half lane = `addr[1]`; little-endian.
- Load extract in LD_CAP: select the lane from `mem_rdata`, then sign- or zero-extend. Result is registered into `resp_rdata` on the LD_CAP→RESP edge.
- `resp_valid`=1 exactly while in RESP. `resp_rdata` and `resp_err` hold until the next RESP and are cleared at accept.

## Timing
- Accept cycle = cycle 0.
- `resp_valid` cycle: load 3, word store 2, sub-word store 3, error 1.
- Memory write commits at the rising edge ending ST_WR or RMW_WR.
- Back-to-back: the next accept is possible in the cycle after RESP. Throughput is 1 request per 3–4 cycles.
- Store then load to the same word sees the new data, because the load's read is issued at least 2 cycles after the write edge.
- Reset values: state IDLE, `req_ready`=1 after release, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- Reset mid-operation: `mem_we` drops asynchronously and no partial RMW write commits. The pending request is discarded with no response.
- `req_*` inputs are ignored outside IDLE.

## Structure
- `types_pkg` additions:
  - `access_size_t` enum: SIZE_B, SIZE_H, SIZE_W.
  - `word_t`, `address_t`, `MEM_SIZE` (already present).
- `lsu_state_t` is local to the module.
- One combinational sub-module, `lsu_lane_align`: takes word, byte offset, size, unsigned and new data. Produces the extended load value and the merged store word; shared by LD_CAP and RMW_WR.

## Test plan
- Word store 0xDEADBEEF to addr 0x10, then word load from 0x10 → `mem_we` pulse at cycle 1 only; load `resp_rdata`=0xDEADBEEF at cycle 3, `resp_err`=0.
- After the above, byte store 0x5A to 0x12, then word load from 0x10 → 0xDE5ABEEF; exactly one `mem_we` pulse, in RMW_WR.
- Load byte 0x13 signed → 0xFFFFFFDE; unsigned → 0x000000DE; half from 0x12 signed → 0xFFFFDE5A.
- Half store to 0x11, and word load from 0x12 → `resp_err`=1 at cycle 1 with `resp_rdata`=0; `mem_we` never asserts; memory unchanged.
- Word load at byte address `MEM_WORDS*4` → `resp_err`=1; size 11 → `resp_err`=1.
- Assert `rst_n`=0 during RMW_WR → `mem_we` falls immediately and the target word is unchanged. After release, `req_ready`=1 and `resp_valid` stays 0.
